kmeans_iter_controller: RTL

KMEANS_ITER_CONTROLLER -- requirements
Module: kmeans_iter_controller

---
 rtl/kmeans_pkg.sv | 24 ++
 rtl/km_delay_line.sv | 30 +++
 rtl/kmeans_iter_controller.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/kmeans_pkg.sv
// Shared state encoding, parameter defaults and helpers for the k-means iteration controller.
package kmeans_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SWEEP     = 2'd1,
        WAIT_ITER = 2'd2,
        REPORT    = 2'd3
    } km_state_e;

    localparam int KM_H_ACTIVE  = 320;
    localparam int KM_V_ACTIVE  = 180;
    localparam int KM_HC_W      = 9;
    localparam int KM_VC_W      = 8;
    localparam int KM_ADDR_W    = 15;
    localparam int KM_MAX_ITERS = 8;
    localparam int KM_PIPE_LAT  = 2;

    // Iteration counter increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/km_delay_line.sv
// Fixed-depth shift register used to align control strobes with point-memory read data.
module km_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift every stage by one each cycle; reset clears the whole line.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= data_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_out = stage_q[DEPTH-1];

endmodule

// File: rtl/kmeans_iter_controller.sv
// Per-frame k-means iteration sequencer: sweeps point memory, waits for the
// clustering core, repeats until convergence/cap/frame start, then reports over UART.
module kmeans_iter_controller
    import kmeans_pkg::*;
#(
    parameter int H_ACTIVE  = KM_H_ACTIVE,
    parameter int V_ACTIVE  = KM_V_ACTIVE,
    parameter int HC_W      = KM_HC_W,
    parameter int VC_W      = KM_VC_W,
    parameter int ADDR_W    = KM_ADDR_W,
    parameter int MAX_ITERS = KM_MAX_ITERS,
    parameter int PIPE_LAT  = KM_PIPE_LAT
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [HC_W-1:0]   hcount_in,
    input  logic [VC_W-1:0]   vcount_in,
    input  logic              camera_valid_in,
    input  logic [ADDR_W-1:0] num_points_in,
    input  logic              iteration_finished_in,
    input  logic              converged_in,
    input  logic              uart_busy_in,
    output logic [ADDR_W-1:0] addrb_out,
    output logic              km_valid_out,
    output logic              start_iteration_out,
    output logic              uart_trigger_out,
    output logic              reset_coms_out,
    output logic [7:0]        iter_count_out,
    output logic              aborted_out,
    output logic              busy_out
);

    km_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] num_q, num_d;
    logic [7:0]        iter_q, iter_d;
    logic              aborted_q, aborted_d;
    logic              first_q, first_d;

    logic              frame_end, frame_start;
    logic              raw_valid, raw_start, report_fire;
    logic [7:0]        iter_inc;
    logic              iter_done;

    assign frame_end   = (hcount_in == HC_W'(H_ACTIVE - 1)) && (vcount_in == VC_W'(V_ACTIVE - 1))
                         && camera_valid_in;
    assign frame_start = (hcount_in == '0) && (vcount_in == '0) && camera_valid_in;
    assign iter_inc    = sat_inc8(iter_q);
    assign iter_done   = converged_in || (iter_inc == 8'(MAX_ITERS));

    // State and datapath registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            num_q     <= '0;
            iter_q    <= '0;
            aborted_q <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            num_q     <= num_d;
            iter_q    <= iter_d;
            aborted_q <= aborted_d;
            first_q   <= first_d;
        end
    end

    // Next-state logic and raw (undelayed) strobes.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        num_d       = num_q;
        iter_d      = iter_q;
        aborted_d   = aborted_q;
        raw_valid   = 1'b0;
        raw_start   = 1'b0;
        report_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_end) begin
                    num_d     = num_points_in;
                    iter_d    = '0;
                    aborted_d = 1'b0;
                    addr_d    = '0;
                    state_d   = (num_points_in == '0) ? REPORT : SWEEP;
                end
            end
            SWEEP: begin
                if (frame_start) begin
                    aborted_d = 1'b1;
                    state_d   = REPORT;
                end else begin
                    raw_valid = 1'b1;
                    if (addr_q == num_q - ADDR_W'(1)) begin
                        state_d = WAIT_ITER;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            WAIT_ITER: begin
                raw_start = first_q && !frame_start;
                // A finish coinciding with frame start is counted first; the
                // frame start only marks an abort if the run was not complete.
                if (iteration_finished_in) begin
                    iter_d = iter_inc;
                    if (iter_done) begin
                        state_d = REPORT;
                    end else if (frame_start) begin
                        aborted_d = 1'b1;
                        state_d   = REPORT;
                    end else begin
                        addr_d  = '0;
                        state_d = SWEEP;
                    end
                end else if (frame_start) begin
                    aborted_d = 1'b1;
                    state_d   = REPORT;
                end
            end
            REPORT: begin
                if (!uart_busy_in) begin
                    report_fire = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        first_d = (state_d == WAIT_ITER) && (state_q != WAIT_ITER);
    end

    km_delay_line #(
        .WIDTH (2),
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .data_in  ({raw_start, raw_valid}),
        .data_out ({start_iteration_out, km_valid_out})
    );

    assign addrb_out        = addr_q;
    assign uart_trigger_out = report_fire;
    assign reset_coms_out   = report_fire;
    assign iter_count_out   = iter_q;
    assign aborted_out      = aborted_q;
    assign busy_out         = (state_q != IDLE);

endmodule
